instruction_fetch_unit: RTL and testbench

//  Upstream stage of register_fetch_unit: owns the PC, fetches one 16-bit word per instruction from

---
 rtl/instruction_fetch_unit_pkg.sv | 22 ++
 rtl/instruction_fetch_unit_if.sv | 33 +++
 rtl/instruction_fetch_unit_instr_decoder.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 101 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the lite16 fetch stage: opcodes, FSM states, decoded flag bundle.
package instruction_fetch_unit_pkg;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_CALL = 4'h4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic ri;
        logic st;
        logic jmp;
        logic fn;
    } flags_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/ack, instruction handshake and redirect.
interface instruction_fetch_unit_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
    logic [3:0]  i4_7;
    logic [3:0]  i8_11;
    logic [3:0]  i12_15;
    logic        ri;
    logic        st;
    logic        jmp;
    logic        fn;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_pc,
        output i4_7, i8_11, i12_15, ri, st, jmp, fn,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_pc,
        input  i4_7, i8_11, i12_15, ri, st, jmp, fn,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/instruction_fetch_unit_instr_decoder.sv
// Combinational split of a 16-bit instruction word into register fields and opcode flags.
module instruction_fetch_unit_instr_decoder
    import instruction_fetch_unit_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  i4_7,
    output logic [3:0]  i8_11,
    output logic [3:0]  i12_15,
    output flags_t      flags
);

    assign i4_7   = instr[7:4];
    assign i8_11  = instr[11:8];
    assign i12_15 = instr[15:12];

    always_comb begin
        flags = '0;
        unique case (instr[3:0])
            OP_LDI:  flags.ri = 1'b1;
            OP_ST:   flags.st = 1'b1;
            OP_JMP:  flags.jmp = 1'b1;
            OP_CALL: begin
                flags.jmp = 1'b1;
                flags.fn  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, holds the fetched word in IR
// and presents it decoded to register fetch with a valid/ready handshake.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_unit_if.master   bus
);

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] addr, addr_nxt;
    logic [15:0] ir, ir_nxt;
    logic [15:0] ipc, ipc_nxt;
    logic        valid, valid_nxt;
    flags_t      flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            addr  <= RESET_PC;
            ir    <= '0;
            ipc   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            addr  <= addr_nxt;
            ir    <= ir_nxt;
            ipc   <= ipc_nxt;
            valid <= valid_nxt;
        end
    end

    // addr tracks pc whenever a new request starts; it only diverges while draining a dead request
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        addr_nxt  = addr;
        ir_nxt    = ir;
        ipc_nxt   = ipc;
        valid_nxt = valid;
        unique case (state)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        pc_nxt   = bus.redirect_pc;
                        addr_nxt = bus.redirect_pc;
                    end else begin
                        ir_nxt    = bus.imem_rdata;
                        ipc_nxt   = pc;
                        pc_nxt    = pc + 16'd1;
                        valid_nxt = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end else if (bus.redirect) begin
                    pc_nxt    = bus.redirect_pc;
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.redirect) pc_nxt = bus.redirect_pc;
                if (bus.imem_ack) begin
                    addr_nxt  = bus.redirect ? bus.redirect_pc : pc;
                    state_nxt = S_FETCH;
                end
            end
            S_ISSUE: begin
                if (bus.redirect || bus.instr_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_FETCH;
                    addr_nxt  = bus.redirect ? bus.redirect_pc : pc;
                    if (bus.redirect) pc_nxt = bus.redirect_pc;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    instruction_fetch_unit_instr_decoder u_decoder (
        .instr  (ir),
        .i4_7   (bus.i4_7),
        .i8_11  (bus.i8_11),
        .i12_15 (bus.i12_15),
        .flags  (flags)
    );

    assign bus.imem_req    = (state != S_ISSUE) && !rst;
    assign bus.imem_addr   = addr;
    assign bus.instr_valid = valid;
    assign bus.instr_pc    = ipc;
    assign bus.ri          = flags.ri;
    assign bus.st          = flags.st;
    assign bus.jmp         = flags.jmp;
    assign bus.fn          = flags.fn;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios followed by random traffic.
module tb_instruction_fetch_unit;

    localparam logic [15:0] RPC = 16'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: what the fetch stage should be doing at the next sample.
    logic [15:0] m_pc;
    logic [15:0] e_addr;
    logic        presenting;
    logic        drop;
    logic        in_rst;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: sample/check outputs, drive inputs, advance the model, wait for next negedge.
    task automatic cyc(input logic a, input logic [15:0] w, input logic rdy,
                       input logic rd, input logic [15:0] tgt, input logic r);
        logic req_s;
        logic ack;
        logic exp_req;
        req_s   = bus.imem_req;
        exp_req = !presenting && !in_rst;
        check("imem_req", {31'd0, req_s}, {31'd0, exp_req});
        check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, presenting});
        if (exp_req) check("imem_addr", {16'd0, bus.imem_addr}, {16'd0, e_addr});
        ack = a && (req_s === 1'b1);

        rst             = r;
        bus.imem_ack    = ack;
        bus.imem_rdata  = w;
        bus.instr_ready = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = tgt;

        if (r) begin
            m_pc = RPC; e_addr = RPC; presenting = 1'b0; drop = 1'b0; in_rst = 1'b1;
        end else begin
            in_rst = 1'b0;
            if (presenting) begin
                if (rd) begin
                    presenting = 1'b0; m_pc = tgt; e_addr = tgt;
                end else if (rdy) begin
                    presenting = 1'b0; e_addr = m_pc;
                end
            end else if (ack) begin
                if (drop) begin
                    drop = 1'b0;
                    if (rd) m_pc = tgt;
                    e_addr = m_pc;
                end else if (rd) begin
                    m_pc = tgt; e_addr = tgt;
                end else begin
                    sb.push_back('{pc: e_addr, word: w});
                    presenting = 1'b1;
                    m_pc = e_addr + 16'd1;
                end
            end else if (rd) begin
                m_pc = tgt;
                drop = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per newly presented instruction, then checks it stays stable.
    logic prev_valid = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1) begin
            if (!prev_valid) begin
                if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else cur = sb.pop_front();
            end
            begin
                int op;
                op = int'(cur.word) % 16;
                check("instr_pc", {16'd0, bus.instr_pc}, {16'd0, cur.pc});
                check("i4_7", {28'd0, bus.i4_7}, (int'(cur.word) / 16) % 16);
                check("i8_11", {28'd0, bus.i8_11}, (int'(cur.word) / 256) % 16);
                check("i12_15", {28'd0, bus.i12_15}, int'(cur.word) / 4096);
                check("ri", {31'd0, bus.ri}, (op == 1) ? 1 : 0);
                check("st", {31'd0, bus.st}, (op == 2) ? 1 : 0);
                check("jmp", {31'd0, bus.jmp}, (op == 3 || op == 4) ? 1 : 0);
                check("fn", {31'd0, bus.fn}, (op == 4) ? 1 : 0);
            end
        end
        prev_valid = (bus.instr_valid === 1'b1);
    end

    initial begin
        logic [15:0] w, t, rnd;
        logic        a, rdy, rd, r;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        m_pc = RPC; e_addr = RPC; presenting = 1'b0; drop = 1'b0; in_rst = 1'b1;
        @(negedge clk);

        repeat (3) cyc(0, 16'h0, 0, 0, 16'h0, 1);
        check("reset_pc", {16'd0, bus.instr_pc}, 32'd0);
        check("reset_fields", {20'd0, bus.i12_15, bus.i8_11, bus.i4_7}, 32'd0);
        check("reset_flags", {28'd0, bus.ri, bus.st, bus.jmp, bus.fn}, 32'd0);
        cyc(0, 16'h0, 0, 0, 16'h0, 0);
        cyc(1, 16'h4321, 0, 0, 16'h0, 0);          // fetch at FFFF
        repeat (5) cyc(0, 16'h0, 0, 0, 16'h0, 0);  // stall in issue
        cyc(0, 16'h0, 1, 0, 16'h0, 0);             // accept
        cyc(0, 16'h0, 0, 1, 16'h0040, 0);          // wrapped address 0000, redirect in flight
        repeat (2) cyc(0, 16'h0, 0, 0, 16'h0, 0);
        cyc(1, 16'h1111, 0, 0, 16'h0, 0);          // dropped
        cyc(1, 16'h5A04, 0, 0, 16'h0, 0);          // call at 0040
        cyc(0, 16'h0, 1, 1, 16'h0100, 0);          // accepted with redirect
        cyc(1, 16'h7773, 0, 0, 16'h0, 0);          // jmp at 0100
        cyc(0, 16'h0, 0, 1, 16'h0200, 0);          // flush held instruction
        cyc(1, 16'h2222, 0, 1, 16'h0300, 0);       // ack and redirect together
        cyc(0, 16'h0, 0, 0, 16'h0, 0);
        cyc(0, 16'h0, 0, 1, 16'h0400, 0);          // enter drain
        cyc(0, 16'h0, 0, 0, 16'h0, 1);             // reset while draining
        cyc(0, 16'h0, 0, 0, 16'h0, 0);

        for (int i = 0; i < 3000; i++) begin
            rnd = 16'($urandom);
            w   = {rnd[15:4], 4'($urandom_range(0, 7))};
            a   = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 9) == 0);
            t   = ($urandom_range(0, 3) == 0) ? (16'hFFFE + 16'($urandom_range(0, 1)))
                                              : 16'($urandom);
            r   = ($urandom_range(0, 199) == 0);
            cyc(a, w, rdy, rd, t, r);
        end

        repeat (2) cyc(0, 16'h0, 1, 0, 16'h0, 0);
        @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
